// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/writeback stage.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned REG_AW = $clog2(NREGS);

  // ALU function select codes (meaning depends on mode)
  localparam logic [3:0] SEL_ARITH_ADD = 4'b1001;
  localparam logic [3:0] SEL_ARITH_SUB = 4'b0110;
  localparam logic [3:0] SEL_LOGIC_AND = 4'b1011;
  localparam logic [3:0] SEL_LOGIC_OR  = 4'b1110;
  localparam logic [3:0] SEL_LOGIC_XOR = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              load;
    logic [DATA_W-1:0] imm;
    logic              mode;
    logic [3:0]        select;
    logic              cin;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
  } cmd_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two captured read ports, one write port,
// one combinational debug port. Register 0 always reads zero.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_re,
  input  logic [REG_AW-1:0] i_ra,
  input  logic [REG_AW-1:0] i_rb,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data_c
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;

  // Storage, write port and captured read ports; r0 writes are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_mem[i] <= '0;
      end
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      if (i_we && (i_waddr != '0)) begin
        r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
        r_rdata_a <= (i_ra == '0) ? '0 : r_mem[i_ra];
        r_rdata_b <= (i_rb == '0) ? '0 : r_mem[i_rb];
      end
    end
  end

  assign o_rdata_a    = r_rdata_a;
  assign o_rdata_b    = r_rdata_b;
  assign o_dbg_data_c = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage in front of the 16-bit combinational ALU.
// Optional macro ALU_ISSUE_CARRY_CHAIN_EN adds cmd_use_flag and a carry
// flag so multi-word add/subtract can chain carry between operations.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_mode,
  input  logic [3:0]        cmd_select,
  input  logic              cmd_cin,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_ra,
  input  logic [REG_AW-1:0] cmd_rb,
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
  input  logic              cmd_use_flag,
`endif
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_select,
  output logic              alu_mode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_cmp,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_cout,
  output logic              res_cmp,
  output logic [REG_AW-1:0] res_rd,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            r_state;
  state_t            w_state_nxt;
  cmd_t              w_cmd;
  logic              w_accept_load;
  logic              w_accept_alu;
  logic              w_capture;
  logic              w_rf_we;
  logic [REG_AW-1:0] w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;
  logic              w_cin_sel;

  logic              r_cmd_ready;
  logic [3:0]        r_alu_select;
  logic              r_alu_mode;
  logic              r_alu_cin;
  logic [REG_AW-1:0] r_rd_pend;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_cout;
  logic              r_res_cmp;
  logic [REG_AW-1:0] r_res_rd;

  assign w_cmd = '{load:   cmd_load,
                   imm:    cmd_imm,
                   mode:   cmd_mode,
                   select: cmd_select,
                   cin:    cmd_cin,
                   rd:     cmd_rd,
                   ra:     cmd_ra,
                   rb:     cmd_rb};

`ifdef ALU_ISSUE_CARRY_CHAIN_EN
  logic r_carry_flag;

  // Carry flag tracks the last ALU carry-out; loads leave it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry_flag <= 1'b0;
    end else if (w_capture) begin
      r_carry_flag <= alu_cout;
    end
  end

  assign w_cin_sel = cmd_use_flag ? r_carry_flag : w_cmd.cin;
`else
  assign w_cin_sel = w_cmd.cin;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and accept/capture decode
  always_comb begin
    w_state_nxt   = r_state;
    w_accept_load = 1'b0;
    w_accept_alu  = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          if (w_cmd.load) begin
            w_accept_load = 1'b1;
            w_state_nxt   = DONE;
          end else begin
            w_accept_alu  = 1'b1;
            w_state_nxt   = EXEC;
          end
        end
      end
      EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Writeback source: ALU capture in EXEC, immediate on load accept
  assign w_rf_we    = w_accept_load | w_capture;
  assign w_rf_waddr = w_capture ? r_rd_pend : w_cmd.rd;
  assign w_rf_wdata = w_capture ? alu_result : w_cmd.imm;

  alu_regfile u_regfile (
    .clk          (clk),
    .rst          (rst),
    .i_re         (w_accept_alu),
    .i_ra         (w_cmd.ra),
    .i_rb         (w_cmd.rb),
    .o_rdata_a    (alu_a),
    .o_rdata_b    (alu_b),
    .i_we         (w_rf_we),
    .i_waddr      (w_rf_waddr),
    .i_wdata      (w_rf_wdata),
    .i_dbg_addr   (dbg_addr),
    .o_dbg_data_c (dbg_data)
  );

  // Registered ALU controls, result capture and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_ready  <= 1'b1;
      r_alu_select <= '0;
      r_alu_mode   <= 1'b0;
      r_alu_cin    <= 1'b0;
      r_rd_pend    <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_cout   <= 1'b0;
      r_res_cmp    <= 1'b0;
      r_res_rd     <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_res_valid <= (w_state_nxt == DONE);
      if (w_accept_alu) begin
        r_alu_select <= w_cmd.select;
        r_alu_mode   <= w_cmd.mode;
        r_alu_cin    <= w_cin_sel;
        r_rd_pend    <= w_cmd.rd;
      end
      if (w_accept_load) begin
        r_res_data <= w_cmd.imm;
        r_res_cout <= 1'b0;
        r_res_cmp  <= 1'b0;
        r_res_rd   <= w_cmd.rd;
      end else if (w_capture) begin
        r_res_data <= alu_result;
        r_res_cout <= alu_cout;
        r_res_cmp  <= alu_cmp;
        r_res_rd   <= r_rd_pend;
      end
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign alu_select = r_alu_select;
  assign alu_mode   = r_alu_mode;
  assign alu_cin    = r_alu_cin;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_cout   = r_res_cout;
  assign res_cmp    = r_res_cmp;
  assign res_rd     = r_res_rd;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, register-file shadow model and
// a result scoreboard keyed on accept order and expected strobe cycle.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_load;
  logic [15:0] cmd_imm;
  logic        cmd_mode;
  logic [3:0]  cmd_select;
  logic        cmd_cin;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_ra;
  logic [2:0]  cmd_rb;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
  logic        cmd_use_flag;
`endif
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_select;
  logic        alu_mode;
  logic        alu_cin;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        alu_cmp;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_cout;
  logic        res_cmp;
  logic [2:0]  res_rd;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  typedef struct {
    logic [15:0] data;
    logic        cout;
    logic        cmp;
    logic [2:0]  rd;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_rf [8];
  logic        m_flag;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_load   (cmd_load),
    .cmd_imm    (cmd_imm),
    .cmd_mode   (cmd_mode),
    .cmd_select (cmd_select),
    .cmd_cin    (cmd_cin),
    .cmd_rd     (cmd_rd),
    .cmd_ra     (cmd_ra),
    .cmd_rb     (cmd_rb),
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
    .cmd_use_flag (cmd_use_flag),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_mode   (alu_mode),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .alu_cmp    (alu_cmp),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_cout   (res_cout),
    .res_cmp    (res_cmp),
    .res_rd     (res_rd),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Behavioural ALU: returns {cout, cmp, result}
  function automatic logic [17:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] sel, input logic mode,
                                         input logic cin);
    logic [16:0] s;
    case ({mode, sel})
      5'b0_1001: s = 17'(a) + 17'(b) + 17'(cin);
      5'b0_0110: s = 17'(a) + 17'(~b) + 17'(cin);
      5'b1_1011: s = {1'b0, a & b};
      5'b1_1110: s = {1'b0, a | b};
      5'b1_0110: s = {1'b0, a ^ b};
      default:   s = {1'b0, a};
    endcase
    return {s[16], (a == b), s[15:0]};
  endfunction

  assign {alu_cout, alu_cmp, alu_result} = alu_fn(alu_a, alu_b, alu_select, alu_mode, alu_cin);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: predict on accept, compare on result strobe
  initial begin
    exp_t        e;
    exp_t        n;
    logic [17:0] r;
    logic        cin_e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        m_flag = 1'b0;
      end else begin
        if (res_valid) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_res_valid", 32'(res_valid), 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("res_data", 32'(res_data), 32'(e.data));
            chk("res_cout", 32'(res_cout), 32'(e.cout));
            chk("res_cmp",  32'(res_cmp),  32'(e.cmp));
            chk("res_rd",   32'(res_rd),   32'(e.rd));
            chk("res_cycle", 32'(cyc),     32'(e.cyc));
          end
        end
        if (cmd_valid && cmd_ready) begin
          n.rd = cmd_rd;
          if (cmd_load) begin
            n.data = cmd_imm;
            n.cout = 1'b0;
            n.cmp  = 1'b0;
            n.cyc  = cyc + 1;
          end else begin
            cin_e = cmd_cin;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
            if (cmd_use_flag) cin_e = m_flag;
`endif
            r      = alu_fn(m_rf[cmd_ra], m_rf[cmd_rb], cmd_select, cmd_mode, cin_e);
            n.data = r[15:0];
            n.cmp  = r[16];
            n.cout = r[17];
            n.cyc  = cyc + 2;
            m_flag = r[17];
          end
          if (cmd_rd != 3'd0) m_rf[cmd_rd] = n.data;
          sb_q.push_back(n);
        end
      end
    end
  end

  // Present a command (called at posedge+1) and return just after its accept edge
  task automatic send(input logic load, input logic [15:0] imm, input logic mode,
                      input logic [3:0] sel, input logic cin,
                      input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    int n;
    cmd_load = load; cmd_imm = imm; cmd_mode = mode; cmd_select = sel;
    cmd_cin = cin; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int last_acc;
    int n;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_load = 1'b0; cmd_imm = '0; cmd_mode = 1'b0;
    cmd_select = '0; cmd_cin = 1'b0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
    dbg_addr = '0;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
    cmd_use_flag = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_alu_a",     32'(alu_a),     32'd0);
    chk("rst_alu_b",     32'(alu_b),     32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;

    // Loads
    send(1'b1, 16'h1234, 1'b0, 4'h0, 1'b0, 3'd1, 3'd0, 3'd0);
    send(1'b1, 16'h00FF, 1'b0, 4'h0, 1'b0, 3'd2, 3'd0, 3'd0);
    drain();
    dbg_addr = 3'd1; #1; chk("dbg_r1", 32'(dbg_data), 32'h1234);
    dbg_addr = 3'd2; #1; chk("dbg_r2", 32'(dbg_data), 32'h00FF);

    // Logic AND r3 = r1 & r2
    send(1'b0, 16'h0, 1'b1, SEL_LOGIC_AND, 1'b0, 3'd3, 3'd1, 3'd2);
    chk("exec_alu_a",   32'(alu_a),      32'h1234);
    chk("exec_alu_b",   32'(alu_b),      32'h00FF);
    chk("exec_alu_sel", 32'(alu_select), 32'hB);
    chk("exec_alu_mode", 32'(alu_mode),  32'd1);
    chk("exec_no_valid", 32'(res_valid), 32'd0);
    drain();
    chk("and_res_data", 32'(res_data), 32'h0034);
    chk("and_res_rd",   32'(res_rd),   32'd3);
    chk("valid_one_cycle", 32'(res_valid), 32'd0);
    dbg_addr = 3'd3; #1; chk("dbg_r3", 32'(dbg_data), 32'h0034);

    // Add then dependent add
    send(1'b0, 16'h0, 1'b0, SEL_ARITH_ADD, 1'b0, 3'd4, 3'd1, 3'd2);
    send(1'b0, 16'h0, 1'b0, SEL_ARITH_ADD, 1'b0, 3'd5, 3'd4, 3'd2);
    chk("dep_alu_a", 32'(alu_a), 32'h1333);
    drain();
    chk("dep_res_data", 32'(res_data), 32'h1432);
    dbg_addr = 3'd4; #1; chk("dbg_r4", 32'(dbg_data), 32'h1333);

    // Continuous valid: r6 += r1 four times, one accept per 3 cycles
    last_acc = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_load = 1'b0; cmd_mode = 1'b0; cmd_select = SEL_ARITH_ADD; cmd_cin = 1'b0;
      cmd_rd = 3'd6; cmd_ra = 3'd6; cmd_rb = 3'd1;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) chk("hold_timeout", 32'd0, 32'd1);
      if (i > 0) chk("accept_gap", 32'(cyc - last_acc), 32'd3);
      last_acc = cyc;
      @(negedge clk); chk("ready_exec", 32'(cmd_ready), 32'd0);
      @(negedge clk); chk("ready_done", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    drain();
    dbg_addr = 3'd6; #1; chk("dbg_r6_sum", 32'(dbg_data), 32'h48D0);

    // r0 write dropped, result still reported
    send(1'b1, 16'hBEEF, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    drain();
    chk("r0_res_data", 32'(res_data), 32'hBEEF);
    dbg_addr = 3'd0; #1; chk("dbg_r0", 32'(dbg_data), 32'h0000);

    // Reset in EXEC aborts the op
    send(1'b0, 16'h0, 1'b0, SEL_ARITH_ADD, 1'b1, 3'd7, 3'd1, 3'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstx_res_valid", 32'(res_valid),  32'd0);
    chk("rstx_res_data",  32'(res_data),   32'd0);
    chk("rstx_res_rd",    32'(res_rd),     32'd0);
    chk("rstx_res_flags", 32'({res_cout, res_cmp}), 32'd0);
    chk("rstx_alu_a",     32'(alu_a),      32'd0);
    chk("rstx_alu_b",     32'(alu_b),      32'd0);
    chk("rstx_alu_ctl",   32'({alu_select, alu_mode, alu_cin}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a); #1;
      chk("rstx_dbg", 32'(dbg_data), 32'd0);
    end

`ifdef ALU_ISSUE_CARRY_CHAIN_EN
    // Carry chain: 0xFFFF + 1 sets the flag, next op consumes it
    send(1'b1, 16'hFFFF, 1'b0, 4'h0, 1'b0, 3'd1, 3'd0, 3'd0);
    send(1'b1, 16'h0001, 1'b0, 4'h0, 1'b0, 3'd2, 3'd0, 3'd0);
    send(1'b0, 16'h0, 1'b0, SEL_ARITH_ADD, 1'b0, 3'd3, 3'd1, 3'd2);
    drain();
    chk("cc_cout", 32'(res_cout), 32'd1);
    cmd_use_flag = 1'b1;
    send(1'b0, 16'h0, 1'b0, SEL_ARITH_ADD, 1'b0, 3'd4, 3'd2, 3'd2);
    cmd_use_flag = 1'b0;
    chk("cc_alu_cin", 32'(alu_cin), 32'd1);
    drain();
    chk("cc_res_data", 32'(res_data), 32'h0003);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
